// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider with a registered divided
// output, a period-start tick and glitch-free (period-boundary) reconfiguration.
module clk_div_prog #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic [CNT_W-1:0] high_val,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pend
);

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HI_RST  = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  // Register state (_q) and next-state (_d)
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] per_act_q,  per_act_d;
  logic [CNT_W-1:0] hi_act_q,   hi_act_d;
  logic [CNT_W-1:0] per_pend_q, per_pend_d;
  logic [CNT_W-1:0] hi_pend_q,  hi_pend_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;

  // Sanitised capture values and boundary detection
  logic [CNT_W-1:0] per_san_c;
  logic [CNT_W-1:0] hi_san_c;
  logic             wrap_c;
  logic             boundary_c;

  // Clamp requested settings so every period has at least one high and one low cycle
  always_comb begin
    per_san_c = (div_val < TWO) ? TWO : div_val;
    if (high_val == '0) begin
      hi_san_c = ONE;
    end else if (high_val >= per_san_c) begin
      hi_san_c = per_san_c - ONE;
    end else begin
      hi_san_c = high_val;
    end
  end

  // A period boundary is the last count of a period, or any cycle while disabled
  always_comb begin
    wrap_c     = (cnt_q == (per_act_q - ONE));
    boundary_c = !en || wrap_c;
  end

  // Counter and registered outputs, derived from the current count
  always_comb begin
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    if (en) begin
      cnt_d     = wrap_c ? '0 : (cnt_q + ONE);
      clk_out_d = (cnt_q < hi_act_q);
      tick_d    = (cnt_q == '0);
    end
  end

  // Configuration: capture into pending, apply at a boundary; a load landing on
  // a boundary bypasses the pending registers and is applied directly
  always_comb begin
    per_act_d  = per_act_q;
    hi_act_d   = hi_act_q;
    per_pend_d = per_pend_q;
    hi_pend_d  = hi_pend_q;
    cfg_pend_d = cfg_pend_q;
    if (load && boundary_c) begin
      per_act_d  = per_san_c;
      hi_act_d   = hi_san_c;
      cfg_pend_d = 1'b0;
    end else if (cfg_pend_q && boundary_c) begin
      per_act_d  = per_pend_q;
      hi_act_d   = hi_pend_q;
      cfg_pend_d = 1'b0;
    end else if (load) begin
      per_pend_d = per_san_c;
      hi_pend_d  = hi_san_c;
      cfg_pend_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      per_act_q  <= PER_RST;
      hi_act_q   <= HI_RST;
      per_pend_q <= PER_RST;
      hi_pend_q  <= HI_RST;
      cfg_pend_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      per_act_q  <= per_act_d;
      hi_act_q   <= hi_act_d;
      per_pend_q <= per_pend_d;
      hi_pend_q  <= hi_pend_d;
      cfg_pend_q <= cfg_pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign cfg_pend = cfg_pend_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider; next generation of the fixed divide-by-2 toggle divider.
- Generates a divided clock-like signal `clk_out` with programmable period and high time, plus a one-cycle `tick` enable pulse at each period start.
- Sits between the board oscillator domain and slower consumers: VGA/pixel timing, frame pacing, UART baud.
- New divide settings are loaded glitch-free: they take effect only at a period boundary.

Parameters:
- CNT_W, 16: width of the counter and of the divide/high-time fields.
- DEFAULT_DIV, 2: period in clk cycles after reset. Must satisfy 2 <= DEFAULT_DIV < 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low forces outputs idle and restarts the period.
- div_val  in  CNT_W  requested period in clk cycles; sampled when load=1.
- high_val  in  CNT_W  requested high time in clk cycles; sampled when load=1.
- load  in  1  one-cycle strobe capturing div_val/high_val into the pending registers.
- clk_out  out  1  divided output, registered.
- tick  out  1  one-cycle pulse, registered; high on the cycle clk_out begins a period.
- cfg_pend  out  1  high while a loaded setting is waiting for a boundary.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - cnt=0, clk_out=0, tick=0, cfg_pend=0.
  - per_act=DEFAULT_DIV, hi_act=DEFAULT_DIV/2.
  - Pending registers are discarded. rst has priority over load and en.
- Sanitising, applied at capture time:
  - per = (div_val<2) ? 2 : div_val.
  - hi = (high_val==0) ? 1 : (high_val>=per) ? per-1 : high_val.
  - Result: clk_out always has at least 1 high and 1 low cycle per period.
- Counter, when en=1: if cnt==per_act-1 (wrap), cnt<=0; else cnt<=cnt+1. Counter is CNT_W bits wide and never exceeds per_act-1.
- Outputs, when en=1 (registered from the current cnt; one-cycle latency):
  - clk_out <= (cnt < hi_act).
  - tick <= (cnt==0).
- Waveform: with en held high after reset, the first edge gives clk_out=1 and tick=1. clk_out is high for hi_act cycles, then low for per_act-hi_act cycles, repeating.
- DEFAULT_DIV=2 reproduces a divide-by-2 toggle that starts with 1 after reset.
- en=0: at each edge cnt<=0, clk_out<=0, tick<=0. Re-asserting en starts a fresh period: the next edge gives clk_out=1, tick=1.
- load=1: sanitised values are written to per_pend/hi_pend and cfg_pend<=1. A later load before application overwrites the pending values; last load wins.
- Application point: a cycle where cfg_pend=1 and either (en=1 and cnt==per_act-1) or en=0. At that edge per_act<=per_pend, hi_act<=hi_pend, cfg_pend<=0.
- load coincident with the application point: the newly captured values bypass the pending registers and are applied at that edge; cfg_pend stays 0.
- Changing per_act to a value below the current cnt cannot happen, because updates occur only at wrap or while cnt is held at 0.
- No combinational path from any input to any output.

Test Plan:
- Reset release, DEFAULT_DIV=2, en=1 -> clk_out sequence 1,0,1,0…; tick 1,0,1,0…; cfg_pend=0.
- At cnt=0 of a div-2 period, load div_val=5, high_val=2 -> cfg_pend=1; current period finishes (clk_out 0); then clk_out 1,1,0,0,0 repeating; tick once per 5 cycles; cfg_pend drops at the wrap edge.
- Clamping:
  - load div_val=1, high_val=0 -> per=2, hi=1.
  - load div_val=4, high_val=7 -> pattern 1,1,1,0.
  - load div_val=0, high_val=0 -> period 2.
- en dropped mid-high-phase of a div-5 config -> next edge clk_out=0, tick=0. Pending load applied while disabled. Re-enable -> clk_out=1, tick=1 on the first edge, then the full new pattern.
- load asserted exactly on the wrap cycle, div_val=3, high_val=1 -> next period immediately 1,0,0; cfg_pend never asserts. Two loads in one period -> only the second takes effect.
- rst asserted mid-period with cfg_pend=1 -> next edge all outputs 0, cfg_pend=0, defaults restored; the pending value is never applied.
